// File: rtl/msx_clken_pkg.sv
// -----------------------------------------------------------------------------
// msx_clken_pkg
// Shared definitions for the MSX clock-enable generator:
//   - LOCK_STATE_W : width of the lock-qualification state register
//   - lock_state_e : lock-qualification FSM states
//       WAIT_LOCK : waiting for the synchronised PLL lock to assert
//       COUNT     : lock seen, counting consecutive stable cycles
//       READY     : lock qualified, enable channels may run
// -----------------------------------------------------------------------------
package msx_clken_pkg;

    localparam int LOCK_STATE_W = 2;

    typedef enum logic [LOCK_STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        READY     = 2'd2
    } lock_state_e;

endpackage : msx_clken_pkg

// File: rtl/msx_clken_channel.sv
// -----------------------------------------------------------------------------
// msx_clken_channel
// One fractional phase-accumulator clock-enable channel.
// Each clock the accumulator either clears (not ready, or phase restart),
// adds the step (run enable) or holds. The carry out of the add becomes a
// registered single-cycle strobe, so the long-run strobe rate is
// f_clk * step / 2^ACC_W.
//
// Ports:
//   clk       in   system clock
//   n_reset   in   asynchronous active-low reset
//   ready_i   in   registered lock-qualified flag from the top level
//   sync_i    in   phase restart: clears the accumulator, wins over en_i
//   en_i      in   run enable: add step_i this cycle
//   step_i    in   phase increment (ACC_W bits)
//   strobe_o  out  registered single-cycle enable strobe
// -----------------------------------------------------------------------------
module msx_clken_channel #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             ready_i,
    input  logic             sync_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] step_i,
    output logic             strobe_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic             strobe_q;
    logic             strobe_d;
    logic [ACC_W:0]   sum_s;

    // Next accumulator value and strobe, in priority: not ready, sync, enable, hold.
    always_comb begin
        sum_s    = {1'b0, acc_q} + {1'b0, step_i};
        acc_d    = acc_q;
        strobe_d = 1'b0;
        if (!ready_i) begin
            acc_d    = {ACC_W{1'b0}};
            strobe_d = 1'b0;
        end else if (sync_i) begin
            acc_d    = {ACC_W{1'b0}};
            strobe_d = 1'b0;
        end else if (en_i) begin
            // The carry of the (ACC_W+1)-bit sum is the strobe; the wrap
            // keeps the fractional remainder so the average rate is exact.
            acc_d    = sum_s[ACC_W-1:0];
            strobe_d = sum_s[ACC_W];
        end else begin
            acc_d    = acc_q;
            strobe_d = 1'b0;
        end
    end

    // Accumulator and strobe registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_q    <= {ACC_W{1'b0}};
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule : msx_clken_channel

// File: rtl/msx_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// msx_clock_enable_gen
// Runs in the PLL output clock domain. Qualifies the raw PLL lock (two-flop
// synchroniser plus a stability counter), then releases NUM_CH independent
// fractional clock-enable channels. Losing lock while ready stops and zeroes
// all channels and raises a sticky lock_lost flag.
//
// Ports:
//   clk         in   system clock (PLL CLKOUT)
//   n_reset     in   asynchronous active-low reset
//   pll_lock    in   raw PLL lock, asynchronous to clk
//   ch_step     in   per-channel phase increment, channel i at [i*ACC_W +: ACC_W]
//   ch_en       in   per-channel run enable
//   ch_sync     in   per-channel phase restart
//   enable_out  out  per-channel registered single-cycle enable strobe
//   ready       out  lock qualified and stable (registered)
//   lock_lost   out  sticky: lock dropped while ready, cleared by n_reset only
// -----------------------------------------------------------------------------
module msx_clock_enable_gen
    import msx_clken_pkg::*;
#(
    parameter int NUM_CH             = 3,
    parameter int ACC_W              = 16,
    parameter int LOCK_STABLE_CYCLES = 4096,
    parameter int CNT_W              = 13
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    pll_lock,
    input  logic [NUM_CH*ACC_W-1:0] ch_step,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH-1:0]       ch_sync,
    output logic [NUM_CH-1:0]       enable_out,
    output logic                    ready,
    output logic                    lock_lost
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic        lock_meta_q;
    logic        lock_s_q;
    lock_state_e state_q;
    lock_state_e state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic        ready_q;
    logic        ready_d;
    logic        lock_lost_q;
    logic        lock_lost_d;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Lock FSM next state and stability counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = {CNT_W{1'b0}};
                if (lock_s_q) begin
                    state_d = COUNT;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            COUNT: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = COUNT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            READY: begin
                cnt_d = {CNT_W{1'b0}};
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // ready and lock_lost next values.
    always_comb begin
        // ready rises on the edge that enters READY, and falls one cycle
        // after the FSM leaves READY, so lock loss shows 3 clks after the
        // raw lock drops.
        ready_d     = (state_d == READY) || (state_q == READY);
        lock_lost_d = lock_lost_q;
        if (ready_q && !ready_d) begin
            lock_lost_d = 1'b1;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    // FSM, counter and status registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= {CNT_W{1'b0}};
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    // Channels see the registered ready, so every accumulator clears and
    // restarts on the same edges.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        msx_clken_channel #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk      (clk),
            .n_reset  (n_reset),
            .ready_i  (ready_q),
            .sync_i   (ch_sync[i]),
            .en_i     (ch_en[i]),
            .step_i   (ch_step[i*ACC_W +: ACC_W]),
            .strobe_o (enable_out[i])
        );
    end

    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;

endmodule : msx_clock_enable_gen

// File: tb/tb_msx_clock_enable_gen.sv
// -----------------------------------------------------------------------------
// Testbench for msx_clock_enable_gen (NUM_CH=3, ACC_W=8, LOCK_STABLE_CYCLES=16).
// The reference model works per clock edge k (counted from reset release):
//   ready after edge k  = pll_lock was sampled high on every edge k-18 .. k-3
//   lock_lost           = ready has ever fallen since reset
//   channel             = integer phase, wrap at 2^ACC_W, carry gives strobe
// -----------------------------------------------------------------------------
module tb_msx_clock_enable_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 8;
    localparam int LSC    = 16;
    localparam int CNT_W  = 13;
    localparam int MAXE   = 8192;

    logic                    clk = 1'b0;
    logic                    n_reset;
    logic                    pll_lock;
    logic [NUM_CH*ACC_W-1:0] ch_step;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_sync;
    logic [NUM_CH-1:0]       enable_out;
    logic                    ready;
    logic                    lock_lost;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit samp [MAXE];
    int ec;
    int last_k;
    bit m_ready;
    bit m_lost;
    int m_acc [NUM_CH];
    bit m_en  [NUM_CH];

    always #5 clk = ~clk;

    msx_clock_enable_gen #(
        .NUM_CH             (NUM_CH),
        .ACC_W              (ACC_W),
        .LOCK_STABLE_CYCLES (LSC),
        .CNT_W              (CNT_W)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .pll_lock   (pll_lock),
        .ch_step    (ch_step),
        .ch_en      (ch_en),
        .ch_sync    (ch_sync),
        .enable_out (enable_out),
        .ready      (ready),
        .lock_lost  (lock_lost)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, last_k);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input logic lk, input logic [NUM_CH*ACC_W-1:0] st,
                              input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] s);
        int  k;
        bit  ok;
        bit  rprev;
        int  stp;
        int  sum;
        k     = ec;
        rprev = m_ready;
        if (k < MAXE) samp[k] = lk;
        ok = (k >= LSC + 2) && (k < MAXE);
        if (ok) begin
            for (int j = k - LSC - 2; j <= k - 3; j++) begin
                if (!samp[j]) ok = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            stp = int'(st[i*ACC_W +: ACC_W]);
            if (!rprev || s[i]) begin
                m_acc[i] = 0;
                m_en[i]  = 1'b0;
            end else if (e[i]) begin
                sum      = m_acc[i] + stp;
                m_en[i]  = (sum >= (1 << ACC_W));
                m_acc[i] = sum % (1 << ACC_W);
            end else begin
                m_en[i]  = 1'b0;
            end
        end
        m_ready = ok;
        if (rprev && !ok) m_lost = 1'b1;
        last_k = k;
        ec++;
    endtask

    // One clock: capture inputs, step the model, compare every output.
    task automatic cyc();
        logic                    lk;
        logic [NUM_CH*ACC_W-1:0] st;
        logic [NUM_CH-1:0]       e;
        logic [NUM_CH-1:0]       s;
        lk = pll_lock;
        st = ch_step;
        e  = ch_en;
        s  = ch_sync;
        @(posedge clk);
        #1;
        model_edge(lk, st, e, s);
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("enable_out[%0d]", i), 32'(enable_out[i]), 32'(m_en[i]));
        end
        check("ready", 32'(ready), 32'(m_ready));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        n_reset = 1'b0;
        #2;
        check("reset enable_out", 32'(enable_out), 32'd0);
        check("reset ready", 32'(ready), 32'd0);
        check("reset lock_lost", 32'(lock_lost), 32'd0);
        ec      = 0;
        m_ready = 1'b0;
        m_lost  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_en[i]  = 1'b0;
        end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic run_until_ready(output int edge_seen);
        edge_seen = -1;
        for (int n = 0; n < 80; n++) begin
            cyc();
            if (ready === 1'b1) begin
                edge_seen = last_k;
                break;
            end
        end
    endtask

    initial begin
        int e_rdy;
        int prev;
        int cnt;
        int adj;
        bit prev_p;
        int d;
        int r;
        int first [NUM_CH];
        int hold;

        n_reset  = 1'b0;
        pll_lock = 1'b0;
        ch_step  = '0;
        ch_en    = '0;
        ch_sync  = '0;
        last_k   = 0;
        do_reset();

        // Lock qualification: raw lock up before edge 10 -> ready after edge 28.
        repeat (10) cyc();
        pll_lock = 1'b1;
        run_until_ready(e_rdy);
        check("ready_rise_edge", 32'(e_rdy), 32'd28);

        // Glitch rejection: 8 high, 1 low, high again from edge 12 -> ready at 30.
        pll_lock = 1'b0;
        do_reset();
        repeat (3) cyc();
        pll_lock = 1'b1;
        repeat (8) cyc();
        pll_lock = 1'b0;
        cyc();
        pll_lock = 1'b1;
        run_until_ready(e_rdy);
        check("glitch_ready_edge", 32'(e_rdy), 32'd30);

        // Integer ratio: step 64 -> one pulse every 4 clks, 16 in 64 adds.
        ch_step[0*ACC_W +: ACC_W] = 8'd64;
        ch_en[0] = 1'b1;
        prev = -1;
        cnt  = 0;
        for (int n = 0; n < 64; n++) begin
            cyc();
            if (enable_out[0] === 1'b1) begin
                if (prev >= 0) check("int_spacing", 32'(last_k - prev), 32'd4);
                prev = last_k;
                cnt++;
            end
        end
        check("int_count", 32'(cnt), 32'd16);

        // Fractional ratio: step 85 -> 85 pulses in 256 adds, never adjacent.
        ch_step[1*ACC_W +: ACC_W] = 8'd85;
        ch_en[1] = 1'b1;
        cnt    = 0;
        adj    = 0;
        prev_p = 1'b0;
        for (int n = 0; n < 256; n++) begin
            cyc();
            if (enable_out[1] === 1'b1) begin
                cnt++;
                if (prev_p) adj++;
            end
            prev_p = (enable_out[1] === 1'b1);
        end
        ch_en[1] = 1'b0;
        check("frac_count", 32'(cnt), 32'd85);
        check("frac_adjacent", 32'(adj), 32'd0);
        check("frac_model_acc", 32'(m_acc[1]), 32'd0);

        // Sync beats enable: no pulse on the sync edge, next pulse two adds later.
        ch_step[2*ACC_W +: ACC_W] = 8'd128;
        ch_en[2] = 1'b1;
        repeat (5) cyc();
        ch_sync[2] = 1'b1;
        cyc();
        check("sync_no_pulse", 32'(enable_out[2]), 32'd0);
        check("sync_model_acc", 32'(m_acc[2]), 32'd0);
        ch_sync[2] = 1'b0;
        cyc();
        check("sync_add1", 32'(enable_out[2]), 32'd0);
        cyc();
        check("sync_add2", 32'(enable_out[2]), 32'd1);

        // Lock loss while running: ready low 3 clks later, lock_lost set.
        pll_lock = 1'b0;
        d = ec;
        e_rdy = -1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (ready === 1'b0 && e_rdy < 0) e_rdy = last_k;
        end
        check("lock_loss_edge", 32'(e_rdy - d), 32'd3);
        check("lock_lost_set", 32'(lock_lost), 32'd1);

        // Re-lock: all channels restart from zero with aligned first pulses.
        for (int i = 0; i < NUM_CH; i++) begin
            ch_step[i*ACC_W +: ACC_W] = 8'd64;
            first[i] = -1;
        end
        ch_en    = 3'b111;
        pll_lock = 1'b1;
        r = ec;
        for (int n = 0; n < 60; n++) begin
            cyc();
            for (int i = 0; i < NUM_CH; i++) begin
                if (enable_out[i] === 1'b1 && first[i] < 0) first[i] = last_k;
            end
        end
        check("relock_first0", 32'(first[0] - r), 32'd22);
        check("relock_align1", 32'(first[1] - r), 32'd22);
        check("relock_align2", 32'(first[2] - r), 32'd22);
        check("lock_lost_sticky", 32'(lock_lost), 32'd1);

        // Randomised run against the model.
        hold = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    case ($urandom_range(0, 3))
                        0:       ch_step[i*ACC_W +: ACC_W] = 8'd0;
                        1:       ch_step[i*ACC_W +: ACC_W] = 8'($urandom_range(128, 255));
                        default: ch_step[i*ACC_W +: ACC_W] = 8'($urandom_range(1, 127));
                    endcase
                end
            end
            if ($urandom_range(0, 19) == 0) ch_en = 3'($urandom);
            for (int i = 0; i < NUM_CH; i++) ch_sync[i] = ($urandom_range(0, 31) == 0);
            if (hold > 0) begin
                hold--;
                pll_lock = (hold == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                hold     = $urandom_range(1, 40);
                pll_lock = 1'b0;
            end
            cyc();
        end

        // Only n_reset clears lock_lost.
        ch_sync  = '0;
        pll_lock = 1'b1;
        do_reset();
        repeat (5) cyc();
        check("lock_lost_cleared", 32'(lock_lost), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_msx_clock_enable_gen
